// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern sequencer for the status LED bank.
// A prescaler turns the system clock into a step event every MAX_COUNT
// enabled cycles; on each step event the selected pattern advances once.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset, overrides everything else
//   enable  1: prescaler runs; 0: prescaler, pattern state and out freeze
//   mode    0 FILL, 1 SCAN, 2 BLINK, 3 HOLD; sampled only at a step event
//   out     registered LED drive, bit 0 is the first LED lit
//   step    registered one-cycle pulse, high while out shows a new step
//
// Handshake: none; enable is a level-sensitive run/freeze qualifier and
// step is a pure status pulse (no ready/back-pressure).
module led_pattern_gen #(
  parameter int NUM_LEDS    = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int MAX_COUNT   = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] out,
  output logic                step
);

  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(MAX_COUNT - 1);
  localparam logic [LW-1:0] TOP_LEVEL = LW'(NUM_LEDS);
  localparam logic [LW-1:0] LAST_POS  = LW'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] ALL_ON = {NUM_LEDS{1'b1}};

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Complete pattern state in one struct so it can be probed as a unit.
  // level is the bar height in FILL and the lit position in SCAN.
  typedef struct packed {
    mode_t         mode_q;
    dir_t          dir;
    logic [LW-1:0] level;
  } pat_state_t;

  logic [COUNT_WIDTH-1:0] counter, counter_n;
  pat_state_t             st, st_n;
  logic [NUM_LEDS-1:0]    out_r, out_n;
  logic                   step_r, step_n;
  logic                   tick;
  logic [LW-1:0]          lvl_n;

  // Thermometer built bit by bit so a full-width shift never occurs.
  function automatic logic [NUM_LEDS-1:0] therm(input logic [LW-1:0] l);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LEDS; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [LW-1:0] l);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LEDS; i++) m[i] = (i == int'(l));
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      st.mode_q <= MODE_FILL;
      st.dir    <= DIR_UP;
      st.level  <= '0;
      out_r     <= '0;
      step_r    <= 1'b0;
    end else begin
      counter <= counter_n;
      st      <= st_n;
      out_r   <= out_n;
      step_r  <= step_n;
    end
  end

  always_comb begin
    tick      = enable && (counter == LAST_COUNT);
    counter_n = counter;
    st_n      = st;
    out_n     = out_r;
    step_n    = 1'b0;
    lvl_n     = st.level;

    if (enable) counter_n = tick ? '0 : counter + COUNT_WIDTH'(1);

    if (tick) begin
      step_n = 1'b1;
      if (mode_t'(mode) != st.mode_q) begin
        // A new mode always restarts from its first step, even if the old
        // mode was at a turnaround on this same step.
        st_n.mode_q = mode_t'(mode);
        st_n.dir    = DIR_UP;
        case (mode_t'(mode))
          MODE_FILL: begin
            st_n.level = LW'(1);
            out_n      = therm(LW'(1));
          end
          MODE_SCAN: begin
            st_n.level = '0;
            out_n      = onehot('0);
          end
          MODE_BLINK: out_n = ALL_ON;
          default: ; // HOLD keeps level and out as they are
        endcase
      end else begin
        case (st.mode_q)
          MODE_FILL: begin
            // Climb while going up and below the top, or when sitting at 0;
            // otherwise descend. Direction flips on reaching either end so
            // the turnaround value is shown exactly once.
            if ((st.dir == DIR_UP && st.level < TOP_LEVEL) || st.level == '0)
              lvl_n = st.level + LW'(1);
            else
              lvl_n = st.level - LW'(1);
            if (lvl_n == TOP_LEVEL)  st_n.dir = DIR_DOWN;
            else if (lvl_n == '0)    st_n.dir = DIR_UP;
            st_n.level = lvl_n;
            out_n      = therm(lvl_n);
          end
          MODE_SCAN: begin
            if (NUM_LEDS > 1) begin
              if ((st.dir == DIR_UP && st.level < LAST_POS) || st.level == '0)
                lvl_n = st.level + LW'(1);
              else
                lvl_n = st.level - LW'(1);
              if (lvl_n == LAST_POS)  st_n.dir = DIR_DOWN;
              else if (lvl_n == '0)   st_n.dir = DIR_UP;
            end
            st_n.level = lvl_n;
            out_n      = onehot(lvl_n);
          end
          MODE_BLINK: out_n = (out_r == ALL_ON) ? '0 : ALL_ON;
          default: ; // HOLD
        endcase
      end
    end
  end

  assign out  = out_r;
  assign step = step_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: bench for led_pattern_gen using three instances:
// a 4-LED bank with a 4-cycle step, a 1-LED bank with a 3-cycle step and an
// 8-LED bank stepping every cycle. Expected LED values are queued when the
// stimulus is applied and popped as each step appears.
module tb_led_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b1, en4 = 1'b1;
  logic [1:0] mode4 = 2'd0;
  logic [3:0] out4;
  logic       step4;

  logic       rst1 = 1'b1, en1 = 1'b1;
  logic [1:0] mode1 = 2'd1;
  logic [0:0] out1;
  logic       step1;

  logic       rst8 = 1'b1, en8 = 1'b1;
  logic [1:0] mode8 = 2'd0;
  logic [7:0] out8;
  logic       step8;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  led_pattern_gen #(.NUM_LEDS(4), .COUNT_WIDTH(8), .MAX_COUNT(4)) u4 (
    .clk(clk), .rst(rst4), .enable(en4), .mode(mode4), .out(out4), .step(step4));
  led_pattern_gen #(.NUM_LEDS(1), .COUNT_WIDTH(8), .MAX_COUNT(3)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .mode(mode1), .out(out1), .step(step1));
  led_pattern_gen #(.NUM_LEDS(8), .COUNT_WIDTH(8), .MAX_COUNT(1)) u8 (
    .clk(clk), .rst(rst8), .enable(en8), .mode(mode8), .out(out8), .step(step8));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next step pulse of u4; cyc = cycles waited, -1 on timeout.
  task automatic wait_step4(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (step4 === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_step1(input int budget, output int cyc);
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (step1 === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    @(negedge clk);
    rst4 = 1'b1; mode4 = 2'd0; en4 = 1'b1;
    @(negedge clk);
    total++;
    if (out4 !== 4'b0000) begin bad++; $display("FAIL reset_out: got %b want 0000", out4); end
    total++;
    if (step4 !== 1'b0) begin bad++; $display("FAIL reset_step: got %b want 0", step4); end
    rst4 = 1'b0;
    exp_q.push_back(8'h01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (step4 !== 1'(k == 4)) begin
        bad++; $display("FAIL first_step_latency: cycle %0d step got %b want %b", k, step4, k == 4);
      end
    end
    e = exp_q.pop_front();
    total++;
    if ({4'b0, out4} !== e) begin bad++; $display("FAIL first_fill: got %b want %b", out4, e[3:0]); end
  endtask

  task automatic test_fill();
    logic [7:0] e;
    int highs;
    exp_q.push_back(8'h03); exp_q.push_back(8'h07); exp_q.push_back(8'h0f);
    exp_q.push_back(8'h07); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    repeat (8) begin
      highs = 0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (step4 === 1'b1) highs++;
      end
      total++;
      if (highs != 1 || step4 !== 1'b1) begin
        bad++; $display("FAIL fill_step_rate: highs got %0d want 1, last step %b want 1", highs, step4);
      end
      e = exp_q.pop_front();
      total++;
      if ({4'b0, out4} !== e) begin bad++; $display("FAIL fill_out: got %b want %b", out4, e[3:0]); end
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] e;
    int cyc;
    exp_q.push_back(8'h03); exp_q.push_back(8'h07);
    exp_q.push_back(8'h0f); exp_q.push_back(8'h07);
    repeat (4) begin
      wait_step4(4, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 4 || {4'b0, out4} !== e) begin
        bad++; $display("FAIL pre_switch: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
      end
    end
    // Now at 0111 going down; change mode mid-interval.
    @(negedge clk); @(negedge clk);
    mode4 = 2'd2;
    @(negedge clk);
    total++;
    if (out4 !== 4'b0111 || step4 !== 1'b0) begin
      bad++; $display("FAIL switch_mid_interval: out %b step %b want out 0111 step 0", out4, step4);
    end
    exp_q.push_back(8'h0f); exp_q.push_back(8'h00); exp_q.push_back(8'h0f);
    for (int i = 0; i < 3; i++) begin
      wait_step4(4, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != (i == 0 ? 1 : 4) || {4'b0, out4} !== e) begin
        bad++; $display("FAIL blink_out: cyc %0d out %b want out %b", cyc, out4, e[3:0]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] e;
    int cyc;
    mode4 = 2'd0;
    exp_q.push_back(8'h01); exp_q.push_back(8'h03);
    repeat (2) begin
      wait_step4(4, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 4 || {4'b0, out4} !== e) begin
        bad++; $display("FAIL hold_setup: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
      end
    end
    mode4 = 2'd3;
    repeat (3) exp_q.push_back(8'h03);
    repeat (3) begin
      wait_step4(4, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 4 || {4'b0, out4} !== e) begin
        bad++; $display("FAIL hold_out: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
      end
    end
  endtask

  task automatic test_enable();
    logic [7:0] e;
    int cyc;
    mode4 = 2'd0;
    exp_q.push_back(8'h01);
    wait_step4(4, cyc);
    e = exp_q.pop_front();
    total++;
    if (cyc != 4 || {4'b0, out4} !== e) begin
      bad++; $display("FAIL enable_setup: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
    end
    // Three more cycles bring the counter to its last value.
    repeat (3) @(negedge clk);
    en4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (step4 !== 1'b0 || out4 !== 4'b0001) begin
        bad++; $display("FAIL enable_freeze: cycle %0d step %b out %b want step 0 out 0001", k, step4, out4);
      end
    end
    en4 = 1'b1;
    exp_q.push_back(8'h03);
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (step4 !== 1'b1 || {4'b0, out4} !== e) begin
      bad++; $display("FAIL enable_resume: step %b out %b want step 1 out %b", step4, out4, e[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    int cyc;
    exp_q.push_back(8'h07); exp_q.push_back(8'h0f);
    repeat (2) begin
      wait_step4(4, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 4 || {4'b0, out4} !== e) begin
        bad++; $display("FAIL reset_mid_setup: cyc %0d out %b want out %b", cyc, out4, e[3:0]);
      end
    end
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    total++;
    if (out4 !== 4'b0000 || step4 !== 1'b0) begin
      bad++; $display("FAIL reset_mid: out %b step %b want out 0000 step 0", out4, step4);
    end
    exp_q.push_back(8'h01);
    wait_step4(8, cyc);
    e = exp_q.pop_front();
    total++;
    if (cyc != 4 || {4'b0, out4} !== e) begin
      bad++; $display("FAIL reset_mid_restart: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
    end
  endtask

  task automatic test_scan();
    logic [7:0] e;
    int cyc;
    rst4 = 1'b1; mode4 = 2'd1;
    @(negedge clk);
    rst4 = 1'b0;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    exp_q.push_back(8'h08); exp_q.push_back(8'h04); exp_q.push_back(8'h02);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    repeat (8) begin
      wait_step4(6, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 4 || {4'b0, out4} !== e) begin
        bad++; $display("FAIL scan_out: cyc %0d out %b want cyc 4 out %b", cyc, out4, e[3:0]);
      end
    end
  endtask

  task automatic test_scan_single();
    logic [7:0] e;
    int cyc;
    @(negedge clk);
    total++;
    if (out1 !== 1'b0 || step1 !== 1'b0) begin
      bad++; $display("FAIL scan1_reset: out %b step %b want 0 0", out1, step1);
    end
    rst1 = 1'b0;
    repeat (5) exp_q.push_back(8'h01);
    repeat (5) begin
      wait_step1(5, cyc);
      e = exp_q.pop_front();
      total++;
      if (cyc != 3 || {7'b0, out1} !== e) begin
        bad++; $display("FAIL scan1_out: cyc %0d out %b want cyc 3 out %b", cyc, out1, e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [8:0] one;
    one = 9'd1;
    @(negedge clk);
    total++;
    if (out8 !== 8'h00 || step8 !== 1'b0) begin
      bad++; $display("FAIL fast_reset: out %b step %b want 00000000 0", out8, step8);
    end
    for (int l = 1; l <= 8; l++) exp_q.push_back(8'((one << l) - 9'd1));
    for (int l = 7; l >= 0; l--) exp_q.push_back(8'((one << l) - 9'd1));
    exp_q.push_back(8'h01);
    rst8 = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (step8 !== 1'b1 || out8 !== e) begin
        bad++; $display("FAIL fast_fill: step %b out %b want step 1 out %b", step8, out8, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_mode_switch();
    test_hold();
    test_enable();
    test_reset_mid();
    test_scan();
    test_scan_single();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
